// File: rtl/prince_key_contract.sv
// prince_key_contract
//   Reverses the PRINCE 128->192 key extension. Three serial 64-bit beats
//   (k0, k0', k1) are collected, the 128-bit key {k0, k1} is rebuilt, and
//   the middle word is checked against the value derived from k0.
//
//   Optional feature: define PRINCE_DEC_KEY_EN to add the 'dec' input,
//   which is sampled with beat2. When dec=1 the delivered key is the PRINCE
//   decryption key {k0', k1 ^ alpha}.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   s_valid    extended-key beat valid
//   s_ready    block can accept a beat (W0/W1/W2, and not in reset)
//   s_data     beat data: beat0 = k0, beat1 = k0', beat2 = k1
//   m_valid    recovered key available (DONE state)
//   m_ready    consumer takes the key
//   m_key      recovered key, k0 in [127:64]
//   m_err      k0' beat did not match the value derived from k0
//   dec        (PRINCE_DEC_KEY_EN only) request decryption key
//   dbg_state  current FSM state (0=W0, 1=W1, 2=W2, 3=DONE)
//
// Handshake: a beat transfers on a rising edge where s_valid & s_ready are
// both 1; the key transfers on a rising edge where m_valid & m_ready are
// both 1. s_data is ignored without s_valid, m_ready is ignored outside DONE.
// Once asserted, m_valid and m_key/m_err hold until the key is taken.

module prince_key_contract (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [63:0]  s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [127:0] m_key,
   output logic         m_err,
`ifdef PRINCE_DEC_KEY_EN
   input  logic         dec,
`endif
   output logic [1:0]   dbg_state
);

   localparam logic [63:0] ALPHA = 64'hC0AC29B7C97C50DD;

   typedef enum logic [1:0] {W0 = 2'd0, W1 = 2'd1, W2 = 2'd2, DONE = 2'd3} state_t;

   state_t      state, state_nxt;
   logic [63:0] k0_q, k0p_q, k1_q;
   logic        err_q;
   logic        dec_q;
   logic        s_acc;
   logic        m_acc;
   logic [63:0] k0p_exp;

   assign s_acc = s_valid & s_ready;
   assign m_acc = m_valid & m_ready;

   // k0' = (k0 >>> 1) ^ (k0 >> 63): plain rotate right, with the old MSB
   // folded once more into bit 0.
   assign k0p_exp = {k0_q[0], k0_q[63:2], k0_q[1] ^ k0_q[63]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= W0;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      case (state)
         W0: begin
            s_ready = rst_n;
            if (s_acc) state_nxt = W1;
         end
         W1: begin
            s_ready = rst_n;
            if (s_acc) state_nxt = W2;
         end
         W2: begin
            s_ready = rst_n;
            if (s_acc) state_nxt = DONE;
         end
         DONE: begin
            m_valid = 1'b1;
            if (m_acc) state_nxt = W0;
         end
         default: state_nxt = W0;
      endcase
   end

   // Beat capture. The middle-word check is registered together with k1 so
   // the error flag is ready in the same cycle as m_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k0_q  <= '0;
         k0p_q <= '0;
         k1_q  <= '0;
         err_q <= 1'b0;
         dec_q <= 1'b0;
      end else if (s_acc) begin
         case (state)
            W0: k0_q  <= s_data;
            W1: k0p_q <= s_data;
            W2: begin
               k1_q  <= s_data;
               err_q <= (k0p_q != k0p_exp);
`ifdef PRINCE_DEC_KEY_EN
               dec_q <= dec;
`else
               dec_q <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

   assign m_key     = dec_q ? {k0p_q, k1_q ^ ALPHA} : {k0_q, k1_q};
   assign m_err     = err_q & m_valid;
   assign dbg_state = state;

endmodule

// File: tb/tb_prince_key_contract.sv
// Directed bench for prince_key_contract. Build with +define+PRINCE_DEC_KEY_EN
// to also exercise the decryption-key path.

module tb_prince_key_contract;

   logic         clk;
   logic         rst_n;
   logic         s_valid;
   logic         s_ready;
   logic [63:0]  s_data;
   logic         m_valid;
   logic         m_ready;
   logic [127:0] m_key;
   logic         m_err;
   logic [1:0]   dbg_state;
`ifdef PRINCE_DEC_KEY_EN
   logic         dec;
`endif

   int checks = 0;
   int errors = 0;

   prince_key_contract dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_key     (m_key),
      .m_err     (m_err),
`ifdef PRINCE_DEC_KEY_EN
      .dec       (dec),
`endif
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver: present one beat until accepted (bounded), then drop valid
   task automatic send_beat(input logic [63:0] d);
      int n;
      n = 0;
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      while (!s_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL send_beat_timeout: s_ready=%0b required 1", s_ready);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_data  = {$urandom, $urandom};
   endtask

   // driver: take the key with a one-cycle m_ready pulse
   task automatic take_key();
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      s_valid = 1'b1;
      s_data = 64'hDEAD_BEEF_0000_1111;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %0b exp 0", s_ready); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b exp 0", m_valid); end
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL reset_m_err: got %0b exp 0", m_err); end
      checks++; if (m_key !== 128'h0) begin errors++; $display("FAIL reset_m_key: got %h exp 0", m_key); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
      s_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_s_ready: got %0b exp 1", s_ready); end
   endtask

   task automatic test_basic();
      send_beat(64'h0000000000000001);
      send_beat(64'h8000000000000000);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b exp 0", m_valid); end
      send_beat(64'h0123456789ABCDEF);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_m_valid: got %0b exp 1", m_valid); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_s_ready: got %0b exp 0", s_ready); end
      checks++; if (m_key !== 128'h00000000000000010123456789ABCDEF) begin errors++; $display("FAIL basic_m_key: got %h exp 00000000000000010123456789abcdef", m_key); end
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL basic_m_err: got %0b exp 0", m_err); end
      take_key();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_after_valid: got %0b exp 0", m_valid); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL basic_after_state: got %0d exp 0", dbg_state); end
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL basic_after_s_ready: got %0b exp 1", s_ready); end
   endtask

   task automatic test_error();
      send_beat(64'hFFFFFFFFFFFFFFFF);
      send_beat(64'hFFFFFFFFFFFFFFFF);
      send_beat(64'h0000000000000000);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL err_m_valid: got %0b exp 1", m_valid); end
      checks++; if (m_err !== 1'b1) begin errors++; $display("FAIL err_m_err: got %0b exp 1", m_err); end
      checks++; if (m_key !== 128'hFFFFFFFFFFFFFFFF0000000000000000) begin errors++; $display("FAIL err_m_key: got %h exp ffffffffffffffff0000000000000000", m_key); end
      take_key();
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL err_after_state: got %0d exp 0", dbg_state); end
   endtask

   task automatic test_stall();
      send_beat(64'h8000000000000000);
      send_beat(64'h4000000000000001);
      send_beat(64'h0000000000000001);
      for (int i = 0; i < 5; i++) begin
         m_ready = 1'b0;
         s_valid = 1'b1;
         s_data  = {$urandom, $urandom};
         checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_m_valid[%0d]: got %0b exp 1", i, m_valid); end
         checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready[%0d]: got %0b exp 0", i, s_ready); end
         checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL stall_m_err[%0d]: got %0b exp 0", i, m_err); end
         checks++; if (m_key !== 128'h80000000000000000000000000000001) begin errors++; $display("FAIL stall_m_key[%0d]: got %h exp 80000000000000000000000000000001", i, m_key); end
         @(posedge clk); #1;
      end
      checks++; if (dbg_state !== 2'd3) begin errors++; $display("FAIL stall_state: got %0d exp 3", dbg_state); end
      s_valid = 1'b0;
      take_key();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %0b exp 0", m_valid); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL stall_release_state: got %0d exp 0", dbg_state); end
   endtask

   task automatic test_gaps();
      logic [63:0] beats [0:2];
      beats[0] = 64'h0000000000000001;
      beats[1] = 64'h8000000000000000;
      beats[2] = 64'h0123456789ABCDEF;
      for (int b = 0; b < 3; b++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            s_data  = {$urandom, $urandom};
            m_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         send_beat(beats[b]);
         s_valid = 1'b1; s_data = beats[b]; #1;
         s_valid = 1'b0; s_data = {$urandom, $urandom};
      end
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL gaps_m_valid: got %0b exp 1", m_valid); end
      checks++; if (m_key !== 128'h00000000000000010123456789ABCDEF) begin errors++; $display("FAIL gaps_m_key: got %h exp 00000000000000010123456789abcdef", m_key); end
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL gaps_m_err: got %0b exp 0", m_err); end
      take_key();
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL gaps_after_state: got %0d exp 0", dbg_state); end
   endtask

   task automatic test_reset_mid();
      send_beat(64'h1111111111111111);
      send_beat(64'h2222222222222222);
      checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL mid_state_before: got %0d exp 2", dbg_state); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL mid_reset_state: got %0d exp 0", dbg_state); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %0b exp 0", m_valid); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_s_ready: got %0b exp 0", s_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_release_s_ready: got %0b exp 1", s_ready); end
      send_beat(64'h8000000000000000);
      send_beat(64'h4000000000000001);
      send_beat(64'h0000000000000001);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL mid_fresh_valid: got %0b exp 1", m_valid); end
      checks++; if (m_key !== 128'h80000000000000000000000000000001) begin errors++; $display("FAIL mid_fresh_key: got %h exp 80000000000000000000000000000001", m_key); end
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL mid_fresh_err: got %0b exp 0", m_err); end
      take_key();
   endtask

   // Beat presented during the DONE->W0 handshake cycle must not be taken;
   // it becomes beat0 of the next key one edge later.
   task automatic test_back_to_back();
      send_beat(64'hFFFFFFFFFFFFFFFF);
      send_beat(64'hFFFFFFFFFFFFFFFE);
      send_beat(64'hA5A5A5A5A5A5A5A5);
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL b2b_first_err: got %0b exp 0", m_err); end
      checks++; if (m_key !== 128'hFFFFFFFFFFFFFFFFA5A5A5A5A5A5A5A5) begin errors++; $display("FAIL b2b_first_key: got %h exp ffffffffffffffffa5a5a5a5a5a5a5a5", m_key); end
      s_valid = 1'b1;
      s_data  = 64'h0000000000000001;
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL b2b_no_overlap: got %0d exp 0", dbg_state); end
      @(posedge clk); #1;
      checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL b2b_beat0_taken: got %0d exp 1", dbg_state); end
      s_valid = 1'b0;
      send_beat(64'h8000000000000000);
      send_beat(64'h0000000000000002);
      checks++; if (m_key !== 128'h00000000000000010000000000000002) begin errors++; $display("FAIL b2b_second_key: got %h exp 00000000000000010000000000000002", m_key); end
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL b2b_second_err: got %0b exp 0", m_err); end
      take_key();
   endtask

`ifdef PRINCE_DEC_KEY_EN
   task automatic test_dec();
      dec = 1'b1;
      send_beat(64'h0);
      send_beat(64'h0);
      send_beat(64'h0);
      dec = 1'b0;
      checks++; if (m_key !== 128'h0000000000000000C0AC29B7C97C50DD) begin errors++; $display("FAIL dec_m_key: got %h exp 0000000000000000c0ac29b7c97c50dd", m_key); end
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL dec_m_err: got %0b exp 0", m_err); end
      take_key();
      dec = 1'b1;
      send_beat(64'hFFFFFFFFFFFFFFFF);
      send_beat(64'hFFFFFFFFFFFFFFFF);
      send_beat(64'h0);
      dec = 1'b0;
      checks++; if (m_key !== 128'hFFFFFFFFFFFFFFFFC0AC29B7C97C50DD) begin errors++; $display("FAIL dec_err_key: got %h exp ffffffffffffffffc0ac29b7c97c50dd", m_key); end
      checks++; if (m_err !== 1'b1) begin errors++; $display("FAIL dec_err_flag: got %0b exp 1", m_err); end
      take_key();
   endtask
`endif

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;
`ifdef PRINCE_DEC_KEY_EN
      dec     = 1'b0;
`endif
      #1;
      test_reset();
      test_basic();
      test_error();
      test_stall();
      test_gaps();
      test_reset_mid();
      test_back_to_back();
`ifdef PRINCE_DEC_KEY_EN
      test_dec();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prince_key_contract.md
PRINCE_KEY_CONTRACT -- requirements
Module: prince_key_contract

Interface
REQ-001 Parameter: none; all widths fixed (64-bit beats, 128-bit key).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 s_valid  input  1  extended-key beat valid.
REQ-005 s_ready  output  1  block accepts beat; transfer when s_valid & s_ready at clock edge.
REQ-006 s_data  input  64  extended-key beat: beat0 = k0, beat1 = k0', beat2 = k1.
REQ-007 m_valid  output  1  recovered key available.
REQ-008 m_ready  input  1  consumer accepts key; transfer when m_valid & m_ready at clock edge.
REQ-009 m_key  output  128  recovered key: {k0, k1}, k0 in [127:64].
REQ-010 m_err  output  1  k0' beat inconsistent with k0; valid while m_valid=1.

Function
REQ-011 Block SHALL reverse the 128->192 PRINCE key extension: collect 3 serial 64-bit beats, rebuild the 128-bit key, check the middle word.
REQ-012 FSM states: W0, W1, W2, DONE; reset state W0.
REQ-013 W0 -> W1 on beat accept, capture k0; W1 -> W2 on accept, capture k0'; W2 -> DONE on accept, capture k1; no accept = hold state.
REQ-014 s_ready = 1 in W0/W1/W2, 0 in DONE; no beats accepted in DONE.
REQ-015 m_valid = 1 only in DONE; asserted the cycle after beat2 is accepted (latency 1 cycle).
REQ-016 DONE -> W0 on m_ready=1; m_key/m_err held stable while m_valid=1 and m_ready=0.
REQ-017 Expected k0' = rotate-right-by-1(k0) with bit 0 additionally XORed with k0[63]; all other bits plain rotation.
REQ-018 m_err = 1 when captured k0' differs from expected k0' in any bit; comparison registered with k1 capture, no extra latency.
REQ-019 m_err does not block delivery; m_key still = {k0, k1} on error.
REQ-020 s_data ignored when s_valid=0; m_ready ignored outside DONE.
REQ-021 No back-to-back overlap: next beat0 accepted at earliest the cycle after the DONE->W0 handshake.

Reset
REQ-022 rst_n=0 SHALL immediately force state W0, m_valid=0, m_err=0, m_key=0, s_ready=0 while asserted.
REQ-023 Reset mid-sequence (W1/W2/DONE) discards all partial or pending data; after release, s_ready=1 and the next accepted beat is beat0.
REQ-024 Internal k0/k0'/k1 registers reset to 0.

Configuration
REQ-025 Macro PRINCE_DEC_KEY_EN; when defined, an extra input port dec (1 bit) exists, sampled with beat2.
REQ-026 With macro, dec=1: m_key = {k0', k1 XOR 0xC0AC29B7C97C50DD} (PRINCE decryption key, alpha reflection); dec=0: m_key = {k0, k1}; m_err identical in both modes.
REQ-027 Without macro: no dec port, m_key always {k0, k1}.

Verification
REQ-028 Beats 0x0000000000000001, 0x8000000000000000, 0x0123456789ABCDEF, m_ready=1 -> m_valid one cycle after beat2, m_key=0x00000000000000010123456789ABCDEF, m_err=0, then back to W0.
REQ-029 Beats 0xFFFFFFFFFFFFFFFF, 0xFFFFFFFFFFFFFFFF, 0x0 -> m_err=1 (expected k0' 0xFFFFFFFFFFFFFFFE), m_key=0xFFFFFFFFFFFFFFFF0000000000000000.
REQ-030 Beats 0x8000000000000000, 0x4000000000000001, 0x1; m_ready=0 for 5 cycles -> m_valid, m_key, m_err=0 stable, s_ready=0 throughout; accept on first m_ready=1.
REQ-031 s_valid toggled 1/0 between beats with random gaps -> same result as gapless; beats with s_valid=0 and garbage s_data ignored.
REQ-032 rst_n pulsed low after beat1 accepted -> m_valid=0, state W0; fresh 3-beat sequence yields correct key with no residue.
REQ-033 PRINCE_DEC_KEY_EN defined, dec=1, beats 0x0, 0x0, 0x0 -> m_key=0x0000000000000000C0AC29B7C97C50DD, m_err=0.
